// File: rtl/brick_pkg.sv
// Shared definitions for the brick wall and the ball block: FSM states,
// brick layout constants and playfield bounds.
package brick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SCAN,
    ST_CLEAR,
    ST_WIN
  } state_t;

  localparam int NUM_BRICKS = 6;

  // Entry k is brick k+1; all bricks share one row.
  localparam logic [NUM_BRICKS-1:0][8:0] BRICK_X =
    {9'd440, 9'd380, 9'd320, 9'd260, 9'd200, 9'd140};
  localparam logic [NUM_BRICKS-1:0][8:0] BRICK_Y = {NUM_BRICKS{9'd80}};

  localparam logic [8:0] FIELD_LEFT   = 9'd133;
  localparam logic [8:0] FIELD_RIGHT  = 9'd505;
  localparam logic [8:0] FIELD_BOTTOM = 9'd459;

endpackage

// File: rtl/brick_field_if.sv
// Ball/brick link: ball position strobe in, wall state and hit report out.
interface brick_field_if;
  import brick_pkg::*;

  logic [8:0]            ball_x;
  logic [8:0]            ball_y;
  logic                  ball_valid;
  logic                  busy;
  logic [NUM_BRICKS-1:0] bricks_exist;
  logic                  hit_pulse;
  logic [2:0]            hit_index;

  modport master (
    output ball_x, ball_y, ball_valid,
    input  busy, bricks_exist, hit_pulse, hit_index
  );

  modport slave (
    input  ball_x, ball_y, ball_valid,
    output busy, bricks_exist, hit_pulse, hit_index
  );
endinterface

// File: rtl/brick_hit_test.sv
// Combinational ball/brick overlap test; sums are 10 bits so nothing wraps.
module brick_hit_test #(
  parameter int BALL_SZ = 20,
  parameter int BRICK_W = 57,
  parameter int BRICK_H = 19
) (
  input  logic [8:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [8:0] brk_x,
  input  logic [8:0] brk_y,
  input  logic       alive,
  output logic       hit
);
  logic [9:0] bx, by, kx, ky;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign kx = {1'b0, brk_x};
  assign ky = {1'b0, brk_y};

  assign hit = alive
            && (bx <= kx + 10'(BRICK_W))
            && (bx + 10'(BALL_SZ) >= kx)
            && (by <= ky + 10'(BRICK_H))
            && (by + 10'(BALL_SZ) >= ky);
endmodule

// File: rtl/brick_field.sv
// Brick wall owner: scans the six bricks one per cycle against each accepted
// ball position and clears the lowest-index brick the ball overlaps.
module brick_field
  import brick_pkg::*;
#(
  parameter int BALL_SZ = 20,
  parameter int BRICK_W = 57,
  parameter int BRICK_H = 19,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  brick_field_if.slave       bus,
  output logic [8:0]         brick1_x,
  output logic [8:0]         brick2_x,
  output logic [8:0]         brick3_x,
  output logic [8:0]         brick4_x,
  output logic [8:0]         brick5_x,
  output logic [8:0]         brick6_x,
  output logic [8:0]         brick1_y,
  output logic [8:0]         brick2_y,
  output logic [8:0]         brick3_y,
  output logic [8:0]         brick4_y,
  output logic [8:0]         brick5_y,
  output logic [8:0]         brick6_y,
  output logic [SCORE_W-1:0] score,
  output logic               all_cleared
);
  state_t                      state, nxt;
  logic [2:0]                  idx, idx_n;
  logic [8:0]                  lat_x, lat_y, lat_x_n, lat_y_n;
  logic [NUM_BRICKS-1:0]       exist, exist_n;
  logic [SCORE_W-1:0]          score_n;
  logic                        pulse, pulse_n;
  logic [2:0]                  hidx, hidx_n;
  logic                        busy_q, busy_n, won_n;
  logic [NUM_BRICKS-1:0][8:0]  brk_x, brk_y;
  logic                        hit;

  brick_hit_test #(
    .BALL_SZ(BALL_SZ),
    .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H)
  ) u_hit (
    .ball_x(lat_x),
    .ball_y(lat_y),
    .brk_x (brk_x[idx]),
    .brk_y (brk_y[idx]),
    .alive (exist[idx]),
    .hit   (hit)
  );

  always_comb begin
    nxt     = state;
    idx_n   = idx;
    lat_x_n = lat_x;
    lat_y_n = lat_y;
    exist_n = exist;
    score_n = score;
    pulse_n = 1'b0;
    hidx_n  = hidx;
    unique case (state)
      ST_ARMED: begin
        if (bus.ball_valid) begin
          lat_x_n = bus.ball_x;
          lat_y_n = bus.ball_y;
          idx_n   = '0;
          nxt     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          exist_n[idx] = 1'b0;
          if (score != '1) score_n = score + 1'b1;
          pulse_n = 1'b1;
          hidx_n  = idx;
          nxt     = ST_CLEAR;
        end else if (idx == 3'(NUM_BRICKS - 1)) begin
          nxt = ST_ARMED;
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      ST_CLEAR: nxt = (exist == '0) ? ST_WIN : ST_ARMED;
      default: ;
    endcase
    // start wins over whatever the state logic decided above
    if (start) begin
      exist_n = '1;
      score_n = '0;
      pulse_n = 1'b0;
      nxt     = ST_ARMED;
    end
    busy_n = (nxt == ST_SCAN) || (nxt == ST_CLEAR);
    won_n  = (nxt == ST_WIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      exist       <= '0;
      score       <= '0;
      pulse       <= 1'b0;
      hidx        <= '0;
      busy_q      <= 1'b0;
      all_cleared <= 1'b0;
    end else begin
      state       <= nxt;
      idx         <= idx_n;
      lat_x       <= lat_x_n;
      lat_y       <= lat_y_n;
      exist       <= exist_n;
      score       <= score_n;
      pulse       <= pulse_n;
      hidx        <= hidx_n;
      busy_q      <= busy_n;
      all_cleared <= won_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_x <= BRICK_X;
      brk_y <= BRICK_Y;
    end else if (start) begin
      brk_x <= BRICK_X;
      brk_y <= BRICK_Y;
    end
  end

  assign bus.bricks_exist = exist;
  assign bus.hit_pulse    = pulse;
  assign bus.hit_index    = hidx;
  assign bus.busy         = busy_q;

  assign brick1_x = brk_x[0];
  assign brick2_x = brk_x[1];
  assign brick3_x = brk_x[2];
  assign brick4_x = brk_x[3];
  assign brick5_x = brk_x[4];
  assign brick6_x = brk_x[5];
  assign brick1_y = brk_y[0];
  assign brick2_y = brk_y[1];
  assign brick3_y = brk_y[2];
  assign brick4_y = brk_y[3];
  assign brick5_y = brk_y[4];
  assign brick6_y = brk_y[5];
endmodule
